// File: rtl/serial_src_pkg.sv
// Shared encodings and constants for the serial pattern source.
package serial_src_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_GAP   = ST_GAP
  } state_e;

  // Idle high keeps the downstream sequence detector parked in its start state.
  localparam logic DEF_IDLE_BIT = 1'b1;

  localparam int unsigned GAP_CNT_W = 8;

endpackage

// File: rtl/sps_hold_buf.sv
// One-entry hold register with full flag; load wins over unload so a
// simultaneous drain-and-refill keeps the entry occupied.
module sps_hold_buf #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              unload,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full <= 1'b0;
      dout <= '0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_pattern_source.sv
// Parallel-to-serial source: MSB-first words on x_out, shifter plus one
// hold entry for gapless back-to-back streaming, optional idle gap per word.
module serial_pattern_source
  import serial_src_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter logic        IDLE_BIT   = DEF_IDLE_BIT,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          din,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic                       x_out,
  output logic                       bit_valid,
  output logic                       frame_start,
  output logic [$clog2(DATA_W)-1:0]  bit_cnt
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  state_e             state, state_nxt;
  logic [DATA_W-1:0]  sh, sh_nxt;
  logic               x_nxt, bv_nxt, fs_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [DATA_W-1:0]  word;
  logic [DATA_W-1:0]  hold_q;
  logic               hold_full, hold_load, hold_unload;
  logic               accept, word_avail, load_sh;
  logic               gap_load, gap_zero;

  assign din_ready  = !hold_full;
  assign accept     = din_valid && !hold_full;
  assign word_avail = hold_full || accept;

  sps_hold_buf #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk    (clk),
    .reset  (reset),
    .load   (hold_load),
    .unload (hold_unload),
    .din    (din),
    .dout   (hold_q),
    .full   (hold_full)
  );

  // Gap counter only exists when a gap is configured.
  generate
    if (GAP_CYCLES != 0) begin : g_gap
      logic [GAP_CNT_W-1:0] gap_cnt;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          gap_cnt <= '0;
        end else if (gap_load) begin
          gap_cnt <= GAP_CNT_W'(GAP_CYCLES - 1);
        end else if (gap_cnt != '0) begin
          gap_cnt <= gap_cnt - GAP_CNT_W'(1);
        end
      end

      assign gap_zero = (gap_cnt == '0);
    end else begin : g_nogap
      logic unused_gap_load;
      assign unused_gap_load = gap_load;
      assign gap_zero        = 1'b1;
    end
  endgenerate

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    x_nxt     = x_out;
    bv_nxt    = bit_valid;
    fs_nxt    = 1'b0;
    cnt_nxt   = bit_cnt;
    load_sh   = 1'b0;
    gap_load  = 1'b0;
    word      = hold_full ? hold_q : din;

    case (state)
      S_IDLE: begin
        if (accept) load_sh = 1'b1;
      end
      S_SHIFT: begin
        if (bit_cnt != '0) begin
          cnt_nxt = bit_cnt - CNT_W'(1);
          x_nxt   = sh[DATA_W-1];
          sh_nxt  = {sh[DATA_W-2:0], 1'b0};
        end else if (GAP_CYCLES != 0) begin
          state_nxt = S_GAP;
          gap_load  = 1'b1;
          x_nxt     = IDLE_BIT;
          bv_nxt    = 1'b0;
          cnt_nxt   = '0;
        end else if (word_avail) begin
          load_sh = 1'b1;
        end else begin
          state_nxt = S_IDLE;
          x_nxt     = IDLE_BIT;
          bv_nxt    = 1'b0;
          cnt_nxt   = '0;
        end
      end
      S_GAP: begin
        if (gap_zero) begin
          if (word_avail) load_sh = 1'b1;
          else            state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        x_nxt     = IDLE_BIT;
        bv_nxt    = 1'b0;
        cnt_nxt   = '0;
      end
    endcase

    // Oldest word (hold first) goes to the shifter; MSB appears next cycle.
    if (load_sh) begin
      state_nxt = S_SHIFT;
      x_nxt     = word[DATA_W-1];
      sh_nxt    = {word[DATA_W-2:0], 1'b0};
      bv_nxt    = 1'b1;
      fs_nxt    = 1'b1;
      cnt_nxt   = CNT_W'(DATA_W - 1);
    end

    hold_load   = accept && (!load_sh || hold_full);
    hold_unload = load_sh && hold_full;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      sh          <= '0;
      x_out       <= IDLE_BIT;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      bit_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      sh          <= sh_nxt;
      x_out       <= x_nxt;
      bit_valid   <= bv_nxt;
      frame_start <= fs_nxt;
      bit_cnt     <= cnt_nxt;
    end
  end

endmodule
